chr_mem: RTL and testbench

- Second-generation PPU pattern-memory bridge between the NES PPU bus and the shared SDRAM.
- Serves CHR-ROM reads and adds CHR-RAM writes, implemented as a byte read-modify-write on the 16-bit SDRAM word.
- Settle delay, hold timeout and synchroniser depth are parametrised.
- Sits beside the PRG bridge and behind the SDRAM arbiter port, using the toggle req/ack handshake.

---
 rtl/chr_pkg.sv | 15 +
 rtl/sdram_bus.sv | 13 +
 rtl/strobe_sync.sv | 26 ++
 rtl/chr_mem.sv | 170 +++++++++++++++++
 tb/tb_chr_mem.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chr_pkg.sv
// Shared types for the PPU pattern-memory bridge: FSM states, op kinds and the
// byte-merge helper used for CHR-RAM read-modify-write.
package chr_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, RD_WAIT, WR_WAIT, HOLD} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  // Replace the byte selected by sel (1 = high byte) in a 16-bit SDRAM word.
  function automatic logic [15:0] merge_byte(input logic [15:0] word16,
                                             input logic [7:0]  byte8,
                                             input logic        sel);
    merge_byte = sel ? {byte8, word16[7:0]} : {word16[15:8], byte8};
  endfunction

endpackage

// File: rtl/sdram_bus.sv
// SDRAM arbiter port using a toggle req/ack handshake: a transfer is pending
// while req != ack.
interface sdram_bus #(parameter int ADDR_BITS = 24);
  logic [ADDR_BITS-2:0] address;
  logic                 we;
  logic                 req;
  logic                 ack;
  logic [15:0]          data_read;
  logic [15:0]          data_write;

  modport device (output address, we, req, data_write, input ack, data_read);
  modport host   (input address, we, req, data_write, output ack, data_read);
endinterface

// File: rtl/strobe_sync.sv
// Multi-flop synchroniser for an asynchronous PPU level, with edge pulses taken
// from the two oldest stages.
module strobe_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {STAGES{INIT}};
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q    = sr[STAGES-1];
  assign fall =  sr[STAGES-1] & ~sr[STAGES-2];
  assign rise = ~sr[STAGES-1] &  sr[STAGES-2];

endmodule

// File: rtl/chr_mem.sv
// PPU pattern-memory bridge: CHR-ROM reads and CHR-RAM byte writes (RMW) onto
// the shared SDRAM. Optional one-word read cache under CHR_WORD_CACHE_EN.
module chr_mem
  import chr_pkg::*;
#(
  parameter int ADDR_BITS     = 24,
  parameter int SETTLE_CYCLES = 12,
  parameter int HOLD_TIMEOUT  = 15,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 chr_ram_en,
  input  logic [ADDR_BITS-1:0] offset,
  sdram_bus.device             ram,
  input  logic                 ppu_rd_n,
  input  logic                 ppu_wr_n,
  input  logic                 ciram_ce,
  input  logic [12:0]          addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           data,
  output logic                 busy
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_TIMEOUT - 1);

  state_t                 state;
  op_t                    op;
  logic [7:0]             cnt;
  logic                   low_bit;
  logic [7:0]             wdata_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   rd_q, rd_fall, rd_rise;
  logic                   wr_q, wr_fall, wr_rise;
  logic                   ce_q, ce_fall, ce_rise;
  logic                   unused_edges;

  strobe_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .d(ppu_rd_n), .q(rd_q), .fall(rd_fall), .rise(rd_rise));
  strobe_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .d(ppu_wr_n), .q(wr_q), .fall(wr_fall), .rise(wr_rise));
  strobe_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_ce_sync (
    .clk(clk), .rst_n(rst_n), .d(ciram_ce), .q(ce_q), .fall(ce_fall), .rise(ce_rise));

  assign unused_edges = ^{rd_rise, wr_rise, ce_fall, ce_rise};
  assign busy         = (state != IDLE);

`ifdef CHR_WORD_CACHE_EN
  logic                 cache_vld;
  logic [ADDR_BITS-2:0] cache_addr;
  logic [15:0]          cache_word;
  logic [ADDR_BITS-1:0] offset_q;
  logic                 cache_hit;

  assign cache_hit = cache_vld && (cache_addr == addr_q[ADDR_BITS-1:1]) && (op == OP_READ);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op             <= OP_READ;
      cnt            <= '0;
      low_bit        <= 1'b0;
      wdata_q        <= '0;
      addr_q         <= '0;
      data           <= '0;
      ram.req        <= 1'b0;
      ram.we         <= 1'b0;
      ram.address    <= '0;
      ram.data_write <= '0;
`ifdef CHR_WORD_CACHE_EN
      cache_vld      <= 1'b0;
      cache_addr     <= '0;
      cache_word     <= '0;
      offset_q       <= '0;
`endif
    end else begin
      addr_q <= {{(ADDR_BITS-13){1'b0}}, addr} | offset;
      case (state)
        IDLE: begin
          if (enable) begin
            if (rd_fall) begin
              op    <= OP_READ;
              cnt   <= '0;
              state <= SETTLE;
            end else if (wr_fall && chr_ram_en) begin
              op    <= OP_WRITE;
              cnt   <= '0;
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == SETTLE_LAST) begin
            if (!ce_q) begin
              state <= IDLE;
            end else begin
              low_bit <= addr_q[0];
              wdata_q <= wdata;
`ifdef CHR_WORD_CACHE_EN
              if (cache_hit) begin
                data  <= addr_q[0] ? cache_word[15:8] : cache_word[7:0];
                cnt   <= '0;
                state <= HOLD;
              end else
`endif
              begin
                ram.address <= addr_q[ADDR_BITS-1:1];
                ram.we      <= 1'b0;
                ram.req     <= ~ram.req;
                state       <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          // A pending request is always allowed to finish; only its result is dropped.
          if (ram.req == ram.ack) begin
            if (!enable) begin
              state <= IDLE;
            end else if (op == OP_READ) begin
              data  <= low_bit ? ram.data_read[15:8] : ram.data_read[7:0];
              cnt   <= '0;
              state <= HOLD;
`ifdef CHR_WORD_CACHE_EN
              cache_vld  <= 1'b1;
              cache_addr <= ram.address;
              cache_word <= ram.data_read;
`endif
            end else begin
              ram.data_write <= merge_byte(ram.data_read, wdata_q, low_bit);
              ram.we         <= 1'b1;
              ram.req        <= ~ram.req;
              state          <= WR_WAIT;
`ifdef CHR_WORD_CACHE_EN
              cache_vld  <= 1'b1;
              cache_addr <= ram.address;
              cache_word <= merge_byte(ram.data_read, wdata_q, low_bit);
`endif
            end
          end
        end
        WR_WAIT: begin
          if (ram.req == ram.ack) begin
            ram.we <= 1'b0;
            cnt    <= '0;
            state  <= enable ? HOLD : IDLE;
          end
        end
        HOLD: begin
          cnt <= cnt + 8'd1;
          if (!enable || ((op == OP_READ) ? rd_q : wr_q) || cnt == HOLD_LAST)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CHR_WORD_CACHE_EN
      // A base change remaps every word, so the cached copy is stale.
      offset_q <= offset;
      if (offset != offset_q) cache_vld <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_chr_mem.sv
// Self-checking bench for chr_mem: directed vector table, multi-cycle corner
// sequences and a randomized run against a byte-level memory model.
module tb_chr_mem;

  localparam int AB = 24;
  localparam int SC = 12;
  localparam int HT = 15;
  localparam int SS = 2;
`ifdef CHR_WORD_CACHE_EN
  localparam int CACHE_ON = 1;
`else
  localparam int CACHE_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, chr_ram_en, ppu_rd_n, ppu_wr_n, ciram_ce;
  logic [23:0] offset;
  logic [12:0] addr;
  logic [7:0]  wdata, data;
  logic        busy;

  sdram_bus #(.ADDR_BITS(AB)) ram_if ();

  chr_mem #(.ADDR_BITS(AB), .SETTLE_CYCLES(SC), .HOLD_TIMEOUT(HT), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chr_ram_en(chr_ram_en), .offset(offset),
    .ram(ram_if), .ppu_rd_n(ppu_rd_n), .ppu_wr_n(ppu_wr_n), .ciram_ce(ciram_ce),
    .addr(addr), .wdata(wdata), .data(data), .busy(busy));

  always #4 clk = ~clk;

  // SDRAM model: answers each toggled request after ack_delay cycles.
  bit [15:0]   mem [int];
  int          ack_delay = 3;
  int          req_count = 0;
  logic [22:0] log_addr [$];
  logic        log_we [$];
  logic        pend;
  int          dly;
  bit          busy_seen = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_if.ack       <= 1'b0;
      ram_if.data_read <= 16'h0;
      pend             <= 1'b0;
      dly              <= 0;
    end else if (!pend) begin
      if (ram_if.req != ram_if.ack) begin
        pend <= 1'b1;
        dly  <= ack_delay;
        req_count++;
        log_addr.push_back(ram_if.address);
        log_we.push_back(ram_if.we);
      end
    end else if (dly <= 1) begin
      pend       <= 1'b0;
      ram_if.ack <= ram_if.req;
      if (ram_if.we) mem[int'(ram_if.address)] = ram_if.data_write;
      else           ram_if.data_read <= mem[int'(ram_if.address)];
    end else begin
      dly <= dly - 1;
    end
  end

  always @(posedge clk) if (busy) busy_seen = 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic clear_cache(input logic [23:0] off);
    @(negedge clk); offset = ~off;
    @(negedge clk); offset = off;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 80) begin @(negedge clk); n++; end
    if (busy) bound_fail(name);
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic access(input bit wr, input logic [12:0] a, input logic [7:0] wd);
    @(negedge clk); addr = a; wdata = wd; ciram_ce = 1'b1;
    @(negedge clk);
    if (wr) ppu_wr_n = 1'b0; else ppu_rd_n = 1'b0;
    repeat (30) @(negedge clk);
    ppu_rd_n = 1'b1; ppu_wr_n = 1'b1;
    wait_idle("access_idle");
  endtask

  typedef struct {
    bit          wr;
    bit          en;
    logic [23:0] off;
    logic [12:0] a;
    logic [7:0]  wd;
    logic [15:0] init;
    logic [7:0]  exp_data;
    int          exp_reqs;
    logic [22:0] exp_addr;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [6];
  bit [7:0] ref_b [int];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 24'h040000, 13'h0011, 8'h00, 16'hBEEF, 8'hBE, 1, 23'h020008, 16'hBEEF};
    vecs[1] = '{1, 1, 24'h040000, 13'h0010, 8'h5A, 16'h1234, 8'hBE, 2, 23'h020008, 16'h125A};
    vecs[2] = '{1, 0, 24'h040000, 13'h0010, 8'h5A, 16'h1234, 8'hBE, 0, 23'h020008, 16'h1234};
    vecs[3] = '{0, 0, 24'h040000, 13'h0010, 8'h00, 16'hA55A, 8'h5A, 1, 23'h020008, 16'hA55A};
    vecs[4] = '{1, 1, 24'h040000, 13'h1FFF, 8'h77, 16'h0000, 8'h5A, 2, 23'h020FFF, 16'h7700};
    vecs[5] = '{0, 0, 24'hFF0000, 13'h1FFE, 8'h00, 16'h1357, 8'h57, 1, 23'h7F8FFF, 16'h1357};

    rst_n = 1'b0; enable = 1'b1; chr_ram_en = 1'b0; ppu_rd_n = 1'b1; ppu_wr_n = 1'b1;
    ciram_ce = 1'b0; offset = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", ram_if.req, 1'b0);
    chk("rst_we", ram_if.we, 1'b0);
    chk("rst_address", ram_if.address, 23'h0);
    chk("rst_data_write", ram_if.data_write, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      int word;
      word = int'(({11'b0, vecs[i].a} | vecs[i].off) >> 1);
      mem[word] = vecs[i].init;
      chr_ram_en = vecs[i].en;
      clear_cache(vecs[i].off);
      req_count = 0; log_addr.delete(); log_we.delete(); busy_seen = 0;
      access(vecs[i].wr, vecs[i].a, vecs[i].wd);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d_reqs", i), req_count, vecs[i].exp_reqs);
      chk($sformatf("v%0d_word", i), mem[int'(vecs[i].exp_addr)], vecs[i].exp_word);
      if (vecs[i].exp_reqs == 0) chk($sformatf("v%0d_busy_seen", i), busy_seen, 1'b0);
      if (log_addr.size() > 0) begin
        chk($sformatf("v%0d_addr", i), log_addr[0], vecs[i].exp_addr);
        chk($sformatf("v%0d_we0", i), log_we[0], 1'b0);
      end
      if (log_we.size() > 1) chk($sformatf("v%0d_we1", i), log_we[1], 1'b1);
    end

    // CE inactive: settle runs out, no SDRAM access
    clear_cache(24'h040000);
    req_count = 0;
    @(negedge clk); addr = 13'h0005; ciram_ce = 1'b0;
    @(negedge clk); ppu_rd_n = 1'b0;
    repeat (SS + SC - 1) @(negedge clk);
    chk("ce_busy_last_settle", busy, 1'b1);
    @(negedge clk);
    chk("ce_idle", busy, 1'b0);
    chk("ce_reqs", req_count, 0);
    ppu_rd_n = 1'b1; ciram_ce = 1'b1;
    repeat (6) @(negedge clk);

    // Hold timeout with /RD held low
    mem[32'h20003] = 16'h6C93;
    clear_cache(24'h040000);
    @(negedge clk); addr = 13'h0006;
    @(negedge clk); ppu_rd_n = 1'b0;
    begin
      int n = 0;
      while (data !== 8'h93 && n < 100) begin @(negedge clk); n++; end
      if (data !== 8'h93) bound_fail("hold_data");
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk("hold_timeout_cycles", n, HT);
    end
    ppu_rd_n = 1'b1;
    repeat (6) @(negedge clk);

    // Enable dropped while the read is outstanding, slow ack
    mem[32'h20004] = 16'hD00D;
    clear_cache(24'h040000);
    ack_delay = 20;
    @(negedge clk); addr = 13'h0009;
    @(negedge clk); ppu_rd_n = 1'b0;
    begin
      int n = 0;
      while (ram_if.req === ram_if.ack && n < 60) begin @(negedge clk); n++; end
      if (ram_if.req === ram_if.ack) bound_fail("en_req");
      enable = 1'b0;
      repeat (15) @(negedge clk);
      chk("en_busy_held", busy, 1'b1);
      n = 0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      if (busy) bound_fail("en_idle");
      chk("en_handshake_done", ram_if.req == ram_if.ack, 1'b1);
      chk("en_data_unchanged", data, 8'h93);
    end
    ppu_rd_n = 1'b1; enable = 1'b1; ack_delay = 3;
    repeat (6) @(negedge clk);

    // Two reads of the same word
    mem[32'h28008] = 16'hCAFE;
    clear_cache(24'h050000);
    req_count = 0;
    access(0, 13'h0010, 8'h00);
    chk("cache_lo", data, 8'hFE);
    access(0, 13'h0011, 8'h00);
    chk("cache_hi", data, 8'hCA);
    chk("cache_reqs", req_count, (CACHE_ON != 0) ? 1 : 2);

    // Randomized reads/writes against a byte-addressed reference
    begin
      logic [7:0] exp_data;
      exp_data = data;
      for (int w = 0; w < 8; w++) begin
        logic [15:0] v;
        v = 16'($urandom);
        mem[32'h20000 + w] = v;
        ref_b[32'h040000 + 2*w]     = v[7:0];
        ref_b[32'h040000 + 2*w + 1] = v[15:8];
      end
      clear_cache(24'h040000);
      for (int k = 0; k < 40; k++) begin
        bit          wr, en;
        logic [12:0] a;
        logic [7:0]  wd;
        wr = 1'($urandom_range(0, 1));
        en = 1'($urandom_range(0, 1));
        a  = 13'($urandom_range(0, 15));
        wd = 8'($urandom);
        chr_ram_en = en;
        access(wr, a, wd);
        if (!wr) exp_data = ref_b[32'h040000 + int'(a)];
        else if (en) ref_b[32'h040000 + int'(a)] = wd;
        chk($sformatf("rand%0d_data", k), data, exp_data);
      end
      for (int w = 0; w < 8; w++)
        chk($sformatf("rand_mem%0d", w), mem[32'h20000 + w],
            {ref_b[32'h040000 + 2*w + 1], ref_b[32'h040000 + 2*w]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
